// File: rtl/snn_pkg.sv
// Shared definitions for the LIF neuron update slice: datapath widths,
// sequencer state encoding and a saturating adder used for voltages.
package snn_pkg;

  localparam int unsigned VOLT_W = 16;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CALC,
    ST_WRITE,
    ST_CLR,
    ST_FIN
  } lif_state_e;

  // Adds two 18-bit signed operands and clamps the result into the
  // 16-bit signed voltage range.
  function automatic logic signed [VOLT_W-1:0] sat_add(
    input logic signed [17:0] a,
    input logic signed [17:0] b
  );
    logic signed [18:0] sum;
    logic signed [18:0] vmax;
    logic signed [18:0] vmin;
    vmax = 19'sd32767;
    vmin = -19'sd32768;
    sum  = {a[17], a} + {b[17], b};
    if (sum > vmax) begin
      return 16'sh7fff;
    end else if (sum < vmin) begin
      return 16'sh8000;
    end else begin
      return sum[VOLT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_datapath.sv
// Combinational membrane update for one neuron.
//   pre_i  : current membrane voltage (signed)
//   cur_i  : synaptic input current (signed)
//   v_o    : updated voltage, threshold removed on firing, saturated
//   fire_o : neuron reached threshold this update
module lif_datapath
  import snn_pkg::*;
#(
  parameter logic signed [VOLT_W-1:0] THRESHOLD = 16'sd1024,
  parameter logic signed [VOLT_W-1:0] LEAK      = 16'sd0
) (
  input  logic signed [VOLT_W-1:0] pre_i,
  input  logic signed [VOLT_W-1:0] cur_i,
  output logic signed [VOLT_W-1:0] v_o,
  output logic                     fire_o
);

  logic signed [17:0] sum;
  logic signed [17:0] th18;
  logic signed [17:0] sub18;

  always_comb begin
    // 18 bits holds pre + cur - leak for any 16-bit operands without wrap.
    sum    = {{2{pre_i[VOLT_W-1]}}, pre_i}
           + {{2{cur_i[VOLT_W-1]}}, cur_i}
           - {{2{LEAK[VOLT_W-1]}}, LEAK};
    th18   = {{2{THRESHOLD[VOLT_W-1]}}, THRESHOLD};
    fire_o = (sum >= th18);
    sub18  = fire_o ? -th18 : '0;
    v_o    = sat_add(sum, sub18);
  end

endmodule

// File: rtl/lif_update_engine.sv
// Timestep sequencer for the neuron voltage memory. On start it reads,
// updates and writes back every neuron 0..NEURON_NUM-1 (three cycles per
// neuron); on clear it writes zero to every neuron (one cycle each).
//   clk, rst            : clock, synchronous active-high reset
//   start, clear        : command pulses, ignored while busy; clear wins
//   busy, done          : sequence in progress / one-cycle completion pulse
//   cur_addr, cur_data  : current-source index and its data (one cycle later)
//   wr_en, addr         : memory port control (0 = read)
//   post_mem_vol        : memory write data
//   pre_mem_vol         : memory read data, valid the cycle after a read
//   spike_valid/idx     : spike strobe in the neuron's write cycle
module lif_update_engine
  import snn_pkg::*;
#(
  parameter int unsigned              NEURON_NUM = 40,
  parameter logic signed [VOLT_W-1:0] THRESHOLD  = 16'sd1024,
  parameter logic signed [VOLT_W-1:0] LEAK       = 16'sd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clear,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        cur_addr,
  input  logic signed [VOLT_W-1:0] cur_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        addr,
  output logic signed [VOLT_W-1:0] post_mem_vol,
  input  logic signed [VOLT_W-1:0] pre_mem_vol,
  output logic                     spike_valid,
  output logic [ADDR_W-1:0]        spike_idx
);

  lif_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       n_q, n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
  logic signed [VOLT_W-1:0] post_q, post_d;
  logic                    spike_q, spike_d;
  logic [ADDR_W-1:0]       spike_idx_q, spike_idx_d;

  logic signed [VOLT_W-1:0] dp_v;
  logic                     dp_fire;
  logic                     last;

  lif_datapath #(
    .THRESHOLD(THRESHOLD),
    .LEAK     (LEAK)
  ) u_dp (
    .pre_i (pre_mem_vol),
    .cur_i (cur_data),
    .v_o   (dp_v),
    .fire_o(dp_fire)
  );

  assign last = (n_q == ADDR_W'(NEURON_NUM - 1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLR;
          n_d     = '0;
        end else if (start) begin
          state_d = ST_READ;
          n_d     = '0;
        end
      end
      ST_READ:  state_d = ST_CALC;
      ST_CALC:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (last) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_READ;
          n_d     = n_q + ADDR_W'(1);
        end
      end
      ST_CLR: begin
        if (last) begin
          state_d = ST_FIN;
        end else begin
          n_d = n_q + ADDR_W'(1);
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with
    // the state they describe; addr/cur_addr hold outside their phases.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
    wr_en_d     = (state_d == ST_WRITE) || (state_d == ST_CLR);
    addr_d      = (state_d inside {ST_READ, ST_WRITE, ST_CLR}) ? n_d : addr_q;
    cur_addr_d  = (state_d == ST_READ) ? n_d : cur_addr_q;
    post_d      = post_q;
    spike_d     = 1'b0;
    spike_idx_d = spike_idx_q;
    if (state_q == ST_CALC) begin
      post_d  = dp_v;
      spike_d = dp_fire;
      if (dp_fire) begin
        spike_idx_d = n_q;
      end
    end
    if (state_d == ST_CLR) begin
      post_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      cur_addr_q  <= '0;
      post_q      <= '0;
      spike_q     <= 1'b0;
      spike_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      cur_addr_q  <= cur_addr_d;
      post_q      <= post_d;
      spike_q     <= spike_d;
      spike_idx_q <= spike_idx_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_en        = wr_en_q;
  assign addr         = addr_q;
  assign cur_addr     = cur_addr_q;
  assign post_mem_vol = post_q;
  assign spike_valid  = spike_q;
  assign spike_idx    = spike_idx_q;

endmodule

// File: tb/tb_lif_update_engine.sv
// Scoreboard bench for lif_update_engine: a behavioural voltage memory and
// current source surround the DUT; expected writes are queued when a
// command is issued and compared as the DUT writes.
module tb_lif_update_engine;

  localparam int N0 = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, start0, clear0, start1, clear1;

  logic              busy0, done0, wr_en0, sv0;
  logic [5:0]        cur_addr0, addr0, sidx0;
  logic signed [15:0] cur_data0, post0, pre0;
  logic              busy1, done1, wr_en1, sv1;
  logic [5:0]        cur_addr1, addr1, sidx1;
  logic signed [15:0] cur_data1, post1, pre1;

  lif_update_engine #(.NEURON_NUM(N0), .THRESHOLD(16'sd1024), .LEAK(16'sd0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .clear(clear0), .busy(busy0), .done(done0),
    .cur_addr(cur_addr0), .cur_data(cur_data0), .wr_en(wr_en0), .addr(addr0),
    .post_mem_vol(post0), .pre_mem_vol(pre0), .spike_valid(sv0), .spike_idx(sidx0));

  lif_update_engine #(.NEURON_NUM(1), .THRESHOLD(16'sd1024), .LEAK(16'sd10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .clear(clear1), .busy(busy1), .done(done1),
    .cur_addr(cur_addr1), .cur_data(cur_data1), .wr_en(wr_en1), .addr(addr1),
    .post_mem_vol(post1), .pre_mem_vol(pre1), .spike_valid(sv1), .spike_idx(sidx1));

  // Behavioural memories and current sources; preload port for setup.
  logic signed [15:0] mem0 [64];
  logic signed [15:0] mem1 [64];
  logic signed [15:0] curtab0 [64];
  logic signed [15:0] curtab1 [64];
  logic               pl_en, pl_sel;
  logic [5:0]         pl_addr;
  logic signed [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem0[pl_addr] <= pl_data;
    else if (wr_en0) mem0[addr0] <= post0;
    else pre0 <= mem0[addr0];
    cur_data0 <= curtab0[cur_addr0];
  end

  always @(posedge clk) begin
    if (pl_en && pl_sel) mem1[pl_addr] <= pl_data;
    else if (wr_en1) mem1[addr1] <= post1;
    else pre1 <= mem1[addr1];
    cur_data1 <= curtab1[cur_addr1];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int addr;
    int post;
    bit spike;
  } wr_t;

  wr_t sbq[$];
  int  ref0 [64];

  function automatic int lif_ref(input int pre, input int cur, input int leak,
                                 output bit fire);
    int s;
    s    = pre + cur - leak;
    fire = (s >= 1024);
    if (fire) s = s - 1024;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic push_update(input int limit);
    bit f;
    int v;
    for (int n = 0; n < limit; n++) begin
      v = lif_ref(ref0[n], int'(curtab0[n]), 0, f);
      sbq.push_back('{addr: n, post: v, spike: f});
      ref0[n] = v;
    end
  endtask

  task automatic push_clear();
    for (int n = 0; n < N0; n++) begin
      sbq.push_back('{addr: n, post: 0, spike: 1'b0});
      ref0[n] = 0;
    end
  endtask

  task automatic preload(input bit sel, input int a, input int d);
    @(negedge clk);
    pl_sel  = sel;
    pl_addr = 6'(a);
    pl_data = 16'(d);
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Write-side monitor for dut0.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en0) begin
      if (sbq.size() == 0) begin
        check("unexp_wr", wr_en0, 0);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", addr0, e.addr);
        check("wr_post", post0, e.post);
        check("spike_v", sv0, e.spike);
        if (e.spike) check("spike_idx", sidx0, e.addr);
      end
    end else begin
      check("stray_spike", sv0, 0);
    end
  end

  task automatic check_zero0(input string tag);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_wren"}, wr_en0, 0);
    check({tag, "_addr"}, addr0, 0);
    check({tag, "_caddr"}, cur_addr0, 0);
    check({tag, "_post"}, post0, 0);
    check({tag, "_sv"}, sv0, 0);
    check({tag, "_sidx"}, sidx0, 0);
  endtask

  task automatic run_cmd(input bit do_start, input bit do_clear,
                         input int exp_done, input int mid_start);
    int t0, c, first_busy, busy_cnt, done_cyc, done_cnt;
    first_busy = -1; busy_cnt = 0; done_cyc = -1; done_cnt = 0;
    @(negedge clk);
    check("busy_idle", busy0, 0);
    start0 = do_start;
    clear0 = do_clear;
    t0 = cyc;
    for (int k = 0; k < exp_done + 10; k++) begin
      @(negedge clk);
      c = cyc - t0;
      start0 = 1'b0;
      clear0 = 1'b0;
      if (c == mid_start) start0 = 1'b1;
      if (busy0) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
      end
      if (done0) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    start0 = 1'b0;
    check("done_cyc", done_cyc, exp_done);
    check("done_cnt", done_cnt, 1);
    check("busy_first", first_busy, 1);
    check("busy_len", busy_cnt, exp_done);
    check("sb_empty", sbq.size(), 0);
  endtask

  task automatic run_abort();
    int t0, c, done_cnt;
    done_cnt = 0;
    @(negedge clk);
    start0 = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      c = cyc - t0;
      start0 = 1'b0;
      if (c == 51) begin
        check_zero0("abort");
        rst = 1'b0;
      end
      if (c == 50) rst = 1'b1;
      if (done0) done_cnt++;
    end
    check("abort_done", done_cnt, 0);
    check("abort_sb", sbq.size(), 0);
  endtask

  task automatic run_n1();
    int t0, c, done_cyc, wr_cnt, wr_cyc;
    done_cyc = -1; wr_cnt = 0; wr_cyc = -1;
    @(negedge clk);
    start1 = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      c = cyc - t0;
      start1 = 1'b0;
      if (wr_en1) begin
        wr_cnt++;
        wr_cyc = c;
        check("n1_addr", addr1, 0);
        check("n1_post", post1, -5);
        check("n1_spike", sv1, 0);
      end
      if (done1 && done_cyc < 0) done_cyc = c;
    end
    check("n1_wr_cyc", wr_cyc, 3);
    check("n1_wr_cnt", wr_cnt, 1);
    check("n1_done", done_cyc, 4);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; clear0 = 1'b0; start1 = 1'b0; clear1 = 1'b0;
    pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 64; i++) begin
      curtab0[i] = '0;
      curtab1[i] = '0;
      ref0[i]    = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero0("reset");
    check("reset1_busy", busy1, 0);
    check("reset1_wren", wr_en1, 0);
    rst = 1'b0;

    // Junk in memory so the clear has something to erase.
    for (int i = 0; i < N0; i++) preload(1'b0, i, int'($urandom_range(0, 65535)) - 32768);

    push_clear();
    run_cmd(1'b0, 1'b1, N0 + 1, -1);

    for (int i = 0; i < N0; i++) curtab0[i] = 16'sd300;
    for (int r = 0; r < 4; r++) begin
      push_update(N0);
      run_cmd(1'b1, 1'b0, 3 * N0 + 1, -1);
    end

    // Saturation and threshold boundary, with a start pulsed mid-update.
    for (int i = 0; i < N0; i++) curtab0[i] = '0;
    preload(1'b0, 5, 32000);  ref0[5] = 32000;  curtab0[5] = 16'sd32000;
    preload(1'b0, 6, -32000); ref0[6] = -32000; curtab0[6] = -16'sd32000;
    preload(1'b0, 7, 1000);   ref0[7] = 1000;   curtab0[7] = 16'sd24;
    preload(1'b0, 8, 1000);   ref0[8] = 1000;   curtab0[8] = 16'sd23;
    push_update(N0);
    run_cmd(1'b1, 1'b0, 3 * N0 + 1, 30);
    check("sat_hi_ref", ref0[5], 32767);
    check("sat_lo_ref", ref0[6], -32768);

    // Simultaneous start and clear: only the clear runs.
    push_clear();
    run_cmd(1'b1, 1'b1, N0 + 1, -1);

    // Reset during an update: neurons 0..15 are written before the abort.
    for (int i = 0; i < N0; i++) curtab0[i] = 16'(i * 37 - 500);
    push_update(16);
    run_abort();

    push_update(N0);
    run_cmd(1'b1, 1'b0, 3 * N0 + 1, -1);

    // Single-neuron instance with leak.
    preload(1'b1, 0, 5);
    run_n1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lif_update_engine.md
# lif_update_engine

Timestep sequencer on the read/modify/write side of the neuron voltage memory. On each `start` it walks neurons 0..NEURON_NUM-1 in order:
- reads each membrane voltage through the memory's single read-or-write port;
- adds the neuron's input current and subtracts leak;
- compares the result against threshold, emits a spike if it fires, and writes the updated voltage back.

A `clear` command zeroes every voltage. The block sits between the synaptic-current accumulator (source of `cur_data`) and the voltage memory.

## Interface
- NEURON_NUM, 40: neurons per timestep; legal range 1..64.
- THRESHOLD, 16'sd1024: signed firing threshold.
- LEAK, 16'sd0: signed constant subtracted every update.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a timestep update
- clear  in  1  one-cycle pulse; zeroes all voltages
- busy  out  1  high from the cycle after an accepted command until `done`
- done  out  1  one-cycle pulse at the end of an update or clear
- cur_addr  out  6  neuron index for the current source; source returns `cur_data` one cycle later
- cur_data  in  16  signed input current for `cur_addr`
- wr_en  out  1  memory write enable; 0 means read
- addr  out  6  memory address
- post_mem_vol  out  16  signed write data to memory
- pre_mem_vol  in  16  signed read data; valid the cycle after a read is issued
- spike_valid  out  1  one-cycle spike strobe
- spike_idx  out  6  index of the firing neuron; meaningful only with `spike_valid`

## Operation
- States:
  - IDLE
  - READ: addr=n, wr_en=0, cur_addr=n
  - CALC: capture pre_mem_vol and cur_data; compute the new voltage
  - WRITE: addr=n, wr_en=1, post_mem_vol registered; spike_valid asserted here if fired
  - CLR: wr_en=1, post_mem_vol=0, addr=n
  - FIN: done=1, return to IDLE
- Transitions:
  - IDLE: clear → CLR with n=0. Otherwise start → READ with n=0.
  - READ → CALC → WRITE.
  - WRITE: n==NEURON_NUM-1 → FIN, else n+1 → READ.
  - CLR: n==NEURON_NUM-1 → FIN, else n+1 → CLR.
- Arithmetic:
  - s = sext18(pre) + sext18(cur) − sext18(LEAK).
  - If s ≥ THRESHOLD: fire, v = s − THRESHOLD. Otherwise v = s.
  - v saturates to [−32768, 32767].
- Command rules:
  - start/clear are ignored while busy.
  - If start and clear arrive in the same IDLE cycle, clear wins and start is dropped.
- Outside READ/WRITE/CLR: wr_en=0 and addr holds its last value.

## Timing
- Reset values: every output is 0; state=IDLE, n=0. Reset mid-operation aborts in the next cycle with no done pulse and no further writes. Memory contents after an abort are undefined; software issues clear.
- Update latency: start at cycle 0 → READ in cycle 1 → done in cycle 3·NEURON_NUM+1. For N=40, done is in cycle 121.
- Clear latency: done in cycle NEURON_NUM+1.
- busy is high from the first READ/CLR cycle through the FIN cycle inclusive.
- Spike timing: spike_valid for neuron n coincides with its write cycle. At most one spike per 3 cycles.
- Memory contract: pre_mem_vol is read only in CALC, exactly one cycle after READ. In the write cycle the memory does not update pre_mem_vol.
- N=1: the sequence is READ, CALC, WRITE, FIN; done in cycle 4.

## Structure
- Shared package `snn_pkg`:
  - VOLT_W=16, ADDR_W=6
  - state enum
  - saturating-add function
- One natural sub-module, `lif_datapath`: the combinational sum/leak/threshold/saturate logic producing v and fire. The FSM and counter stay in the top module.

## Test plan
- Reset then clear with N=40 → 40 consecutive writes of 0 to addr 0..39; done in cycle 41; busy high cycles 1–41.
- After clear, start with cur_data=300 for all neurons, LEAK=0 → post=300 everywhere, no spikes, done in cycle 121. Repeat three more starts → in the fourth update the sum is 1200, so every neuron spikes and post=176.
- Neuron 5: pre=32000, cur=32000 → s=64000, fires, v=62976 saturates to 32767, spike_idx=5. Neuron 6: pre=−32000, cur=−32000 → post=−32768, no spike.
- LEAK=10, pre=5, cur=0 → post=−5. Threshold boundary: s=1024 → fires, post=0; s=1023 → no fire.
- start and clear in the same cycle → clear sequence only. start pulsed mid-update → ignored, done count stays 1.
- rst asserted in cycle 50 of an update → all outputs 0 next cycle, no done, no writes afterwards. A subsequent start runs a full normal update.
